// File: rtl/pipe_id_regfwd_if.sv
// ----------------------------------------------------------------------------
// pipe_id_regfwd_if
//   Bundles every signal of the decode/operand stage except clock and reset.
//   The stage itself connects through the slave modport. Whatever drives the
//   ID inputs and the EX/MEM/WB feedback connects through the master modport.
//
//   ID side (in)  : i_valid, i_pc4, i_rs, i_rt, i_wr, i_imm, i_sext,
//                   i_use_rs, i_use_rt, i_wreg, i_m2reg, i_brmode, i_ctrl,
//                   i_flush
//   EX/MEM/WB (in): ealu, m_wreg, m_m2reg, m_rn, malu, mmo,
//                   w_wreg, w_rn, w_data
//   Hazard/branch : o_stall, o_redirect, o_target
//   ID/EX (out)   : x_valid, x_wreg, x_m2reg, x_rn, x_a, x_b, x_imm, x_ctrl
//   PIPEID_PERF_EN: adds o_stall_cnt and o_redir_cnt (32-bit saturating)
// ----------------------------------------------------------------------------
interface pipe_id_regfwd_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int CW   = 8
);
    // ID stage instruction, pre-decoded by the control unit
    logic            i_valid;
    logic [XLEN-1:0] i_pc4;
    logic [RA_W-1:0] i_rs;
    logic [RA_W-1:0] i_rt;
    logic [RA_W-1:0] i_wr;
    logic [15:0]     i_imm;
    logic            i_sext;
    logic            i_use_rs;
    logic            i_use_rt;
    logic            i_wreg;
    logic            i_m2reg;
    logic [2:0]      i_brmode;
    logic [CW-1:0]   i_ctrl;
    logic            i_flush;

    // Later-stage results fed back for forwarding and writeback
    logic [XLEN-1:0] ealu;
    logic            m_wreg;
    logic            m_m2reg;
    logic [RA_W-1:0] m_rn;
    logic [XLEN-1:0] malu;
    logic [XLEN-1:0] mmo;
    logic            w_wreg;
    logic [RA_W-1:0] w_rn;
    logic [XLEN-1:0] w_data;

    // Hazard and branch outputs
    logic            o_stall;
    logic            o_redirect;
    logic [XLEN-1:0] o_target;

    // ID/EX pipeline register
    logic            x_valid;
    logic            x_wreg;
    logic            x_m2reg;
    logic [RA_W-1:0] x_rn;
    logic [XLEN-1:0] x_a;
    logic [XLEN-1:0] x_b;
    logic [XLEN-1:0] x_imm;
    logic [CW-1:0]   x_ctrl;

`ifdef PIPEID_PERF_EN
    logic [31:0]     o_stall_cnt;
    logic [31:0]     o_redir_cnt;
`endif

    modport slave (
        input  i_valid, i_pc4, i_rs, i_rt, i_wr, i_imm, i_sext,
               i_use_rs, i_use_rt, i_wreg, i_m2reg, i_brmode, i_ctrl, i_flush,
        input  ealu, m_wreg, m_m2reg, m_rn, malu, mmo, w_wreg, w_rn, w_data,
`ifdef PIPEID_PERF_EN
        output o_stall_cnt, o_redir_cnt,
`endif
        output o_stall, o_redirect, o_target,
        output x_valid, x_wreg, x_m2reg, x_rn, x_a, x_b, x_imm, x_ctrl
    );

    modport master (
        output i_valid, i_pc4, i_rs, i_rt, i_wr, i_imm, i_sext,
               i_use_rs, i_use_rt, i_wreg, i_m2reg, i_brmode, i_ctrl, i_flush,
        output ealu, m_wreg, m_m2reg, m_rn, malu, mmo, w_wreg, w_rn, w_data,
`ifdef PIPEID_PERF_EN
        input  o_stall_cnt, o_redir_cnt,
`endif
        input  o_stall, o_redirect, o_target,
        input  x_valid, x_wreg, x_m2reg, x_rn, x_a, x_b, x_imm, x_ctrl
    );
endinterface

// File: rtl/pipe_id_regfwd.sv
// ----------------------------------------------------------------------------
// pipe_id_regfwd
//   Decode/operand stage of the pipelined CPU. It holds the register file,
//   picks each source operand from EX, MEM, WB or the register file, detects
//   load-use hazards, resolves branches and jr inside ID, and holds the ID/EX
//   pipeline register (bubble on stall, flush or empty ID).
//
//   Ports
//     clock  : rising-edge clock
//     resetn : asynchronous active-low reset; clears ID/EX, register file and
//              the optional counters
//     bus    : pipe_id_regfwd_if.slave (ID inputs, EX/MEM/WB feedback,
//              stall/redirect outputs, ID/EX register outputs)
//
//   Optional build macro PIPEID_PERF_EN adds two 32-bit saturating counters,
//   bus.o_stall_cnt (edges with o_stall=1) and bus.o_redir_cnt (edges with
//   o_redirect=1).
// ----------------------------------------------------------------------------
module pipe_id_regfwd #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int CW   = 8
) (
    input  logic            clock,
    input  logic            resetn,
    pipe_id_regfwd_if.slave bus
);

    localparam int NREG = 2**RA_W;

    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLTZ = 3'b011;
    localparam logic [2:0] BR_BGEZ = 3'b100;
    localparam logic [2:0] BR_JR   = 3'b101;

    // Operand source priority: r0, then the ALU result in EX, then MEM
    // (load data or ALU result), then the register file read.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_ok,
        input logic [RA_W-1:0] ex_rn,
        input logic [XLEN-1:0] ex_alu,
        input logic            mem_wr,
        input logic            mem_ld,
        input logic [RA_W-1:0] mem_rn,
        input logic [XLEN-1:0] mem_alu,
        input logic [XLEN-1:0] mem_ld_data
    );
        if (src == '0)
            return '0;
        else if (ex_ok && (ex_rn == src))
            return ex_alu;
        else if (mem_wr && (mem_rn == src))
            return mem_ld ? mem_ld_data : mem_alu;
        else
            return rf_val;
    endfunction

`ifdef PIPEID_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
`endif

    logic [XLEN-1:0] rf [NREG];

    // ID/EX register contents
    logic                   vld_p1;
    logic                   wreg_p1;
    logic                   m2reg_p1;
    logic [RA_W-1:0]        rn_p1;
    logic [XLEN-1:0]        a_p1;
    logic [XLEN-1:0]        b_p1;
    logic [XLEN-1:0]        imm_p1;
    logic [CW-1:0]          ctrl_p1;

    // ID stage combinational values
    logic [XLEN-1:0]        rs_rf_p0;
    logic [XLEN-1:0]        rt_rf_p0;
    logic signed [XLEN-1:0] a_p0;
    logic signed [XLEN-1:0] b_p0;
    logic [XLEN-1:0]        imm_p0;
    logic [XLEN-1:0]        br_tgt_p0;
    logic                   ex_ok_p0;
    logic                   stall_p0;
    logic                   cond_p0;
    logic                   take_p0;
    logic                   jr_p0;
    logic                   bubble_p0;

    // ---- ID stage (p0): register read, forwarding, hazard, branch ----

    // A write landing on the same edge is returned directly so the reader
    // never sees the stale entry.
    always_comb begin
        rs_rf_p0 = rf[bus.i_rs];
        rt_rf_p0 = rf[bus.i_rt];
        if (bus.w_wreg && (bus.w_rn == bus.i_rs))
            rs_rf_p0 = bus.w_data;
        if (bus.w_wreg && (bus.w_rn == bus.i_rt))
            rt_rf_p0 = bus.w_data;
    end

    // A load sitting in EX has no data yet, so it is never an EX forward source.
    assign ex_ok_p0 = vld_p1 & wreg_p1 & ~m2reg_p1;

    always_comb begin
        a_p0 = fwd_sel(bus.i_rs, rs_rf_p0, ex_ok_p0, rn_p1, bus.ealu,
                       bus.m_wreg, bus.m_m2reg, bus.m_rn, bus.malu, bus.mmo);
        b_p0 = fwd_sel(bus.i_rt, rt_rf_p0, ex_ok_p0, rn_p1, bus.ealu,
                       bus.m_wreg, bus.m_m2reg, bus.m_rn, bus.malu, bus.mmo);
    end

    // Load in EX feeding a real source of the ID instruction: hold one cycle,
    // after which the load sits in MEM and forwards from mmo.
    assign stall_p0 = bus.i_valid & vld_p1 & m2reg_p1 & wreg_p1 &
                      (rn_p1 != '0) &
                      ((bus.i_use_rs & (rn_p1 == bus.i_rs)) |
                       (bus.i_use_rt & (rn_p1 == bus.i_rt)));

    assign imm_p0    = {{(XLEN-16){bus.i_sext & bus.i_imm[15]}}, bus.i_imm};
    assign br_tgt_p0 = bus.i_pc4 + (imm_p0 << 2);

    always_comb begin
        cond_p0 = 1'b0;
        jr_p0   = 1'b0;
        case (bus.i_brmode)
            BR_BEQ:  cond_p0 = (a_p0 == b_p0);
            BR_BNE:  cond_p0 = (a_p0 != b_p0);
            BR_BLTZ: cond_p0 = a_p0[XLEN-1];
            BR_BGEZ: cond_p0 = ~a_p0[XLEN-1];
            BR_JR: begin
                cond_p0 = 1'b1;
                jr_p0   = 1'b1;
            end
            default: cond_p0 = 1'b0;
        endcase
    end

    // A stalled branch resolves on the retry, once its operand is available.
    assign take_p0   = cond_p0 & bus.i_valid & ~stall_p0;
    assign bubble_p0 = stall_p0 | bus.i_flush | ~bus.i_valid;

    assign bus.o_stall    = stall_p0;
    assign bus.o_redirect = take_p0;
    assign bus.o_target   = !take_p0 ? bus.i_pc4 :
                            (jr_p0 ? a_p0 : br_tgt_p0);

    // ---- Register file write (WB) ----

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (bus.w_wreg && (bus.w_rn != '0)) begin
            rf[bus.w_rn] <= bus.w_data;
        end
    end

    // ---- ID/EX boundary (p1) ----

    // Bubbles zero the whole entry so EX never sees leftover operands.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1   <= 1'b0;
            wreg_p1  <= 1'b0;
            m2reg_p1 <= 1'b0;
            rn_p1    <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
            imm_p1   <= '0;
            ctrl_p1  <= '0;
        end else if (bubble_p0) begin
            vld_p1   <= 1'b0;
            wreg_p1  <= 1'b0;
            m2reg_p1 <= 1'b0;
            rn_p1    <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
            imm_p1   <= '0;
            ctrl_p1  <= '0;
        end else begin
            vld_p1   <= 1'b1;
            wreg_p1  <= bus.i_wreg;
            m2reg_p1 <= bus.i_m2reg;
            rn_p1    <= bus.i_wr;
            a_p1     <= a_p0;
            b_p1     <= b_p0;
            imm_p1   <= imm_p0;
            ctrl_p1  <= bus.i_ctrl;
        end
    end

    assign bus.x_valid = vld_p1;
    assign bus.x_wreg  = wreg_p1;
    assign bus.x_m2reg = m2reg_p1;
    assign bus.x_rn    = rn_p1;
    assign bus.x_a     = a_p1;
    assign bus.x_b     = b_p1;
    assign bus.x_imm   = imm_p1;
    assign bus.x_ctrl  = ctrl_p1;

`ifdef PIPEID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] redir_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (stall_p0)
                stall_cnt <= sat_inc(stall_cnt);
            if (take_p0)
                redir_cnt <= sat_inc(redir_cnt);
        end
    end

    assign bus.o_stall_cnt = stall_cnt;
    assign bus.o_redir_cnt = redir_cnt;
`endif

endmodule

// File: tb/tb_pipe_id_regfwd.sv
// ----------------------------------------------------------------------------
// tb_pipe_id_regfwd
//   Scoreboard bench for pipe_id_regfwd. The stimulus process drives one
//   instruction plus EX/MEM/WB feedback per cycle, runs the reference model
//   and pushes the expected stall/redirect/target and the expected ID/EX
//   entry into queues. Two monitors pop and compare: one just after the
//   falling edge for the combinational outputs, one just after the rising
//   edge whenever x_valid is presented.
// ----------------------------------------------------------------------------
module tb_pipe_id_regfwd;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int CW   = 8;

    typedef struct packed {
        logic        i_valid;
        logic [31:0] i_pc4;
        logic [4:0]  i_rs;
        logic [4:0]  i_rt;
        logic [4:0]  i_wr;
        logic [15:0] i_imm;
        logic        i_sext;
        logic        i_use_rs;
        logic        i_use_rt;
        logic        i_wreg;
        logic        i_m2reg;
        logic [2:0]  i_brmode;
        logic [7:0]  i_ctrl;
        logic        i_flush;
        logic [31:0] ealu;
        logic        m_wreg;
        logic        m_m2reg;
        logic [4:0]  m_rn;
        logic [31:0] malu;
        logic [31:0] mmo;
        logic        w_wreg;
        logic [4:0]  w_rn;
        logic [31:0] w_data;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] scnt;
        logic [31:0] rcnt;
    } comb_t;

    typedef struct packed {
        logic [4:0]  rn;
        logic        wreg;
        logic        m2reg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [7:0]  ctrl;
    } xexp_t;

    logic clk;
    logic resetn;

    pipe_id_regfwd_if #(.XLEN(XLEN), .RA_W(RA_W), .CW(CW)) bus ();

    pipe_id_regfwd #(.XLEN(XLEN), .RA_W(RA_W), .CW(CW)) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    comb_t cq[$];
    xexp_t xq[$];

    // Reference model state: architectural registers and what ID/EX should hold
    logic [31:0] mregs [32];
    logic        mx_valid, mx_wreg, mx_m2reg;
    logic [4:0]  mx_rn;
    logic [31:0] mscnt, mrcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mx_valid = 1'b0; mx_wreg = 1'b0; mx_m2reg = 1'b0; mx_rn = 5'd0;
        mscnt = 32'h0; mrcnt = 32'h0;
    endtask

    // Value a source register should supply this cycle.
    function automatic logic [31:0] mfwd(input stim_t s, input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (mx_valid && mx_wreg && !mx_m2reg && mx_rn == r) return s.ealu;
        if (s.m_wreg && s.m_rn == r) return s.m_m2reg ? s.mmo : s.malu;
        if (s.w_wreg && s.w_rn == r) return s.w_data;
        return mregs[r];
    endfunction

    task automatic model(input stim_t s);
        logic [31:0] a, b, immx, tgt;
        logic        stall, taken;
        comb_t       c;
        xexp_t       x;
        a = mfwd(s, s.i_rs);
        b = mfwd(s, s.i_rt);
        stall = s.i_valid && mx_valid && mx_m2reg && mx_wreg && mx_rn != 5'd0 &&
                ((s.i_use_rs && mx_rn == s.i_rs) || (s.i_use_rt && mx_rn == s.i_rt));
        immx = (s.i_sext && s.i_imm[15]) ? {16'hFFFF, s.i_imm} : {16'h0000, s.i_imm};
        case (s.i_brmode)
            3'd1:    taken = (a == b);
            3'd2:    taken = (a != b);
            3'd3:    taken = ($signed(a) < 0);
            3'd4:    taken = ($signed(a) >= 0);
            3'd5:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
        taken = taken && s.i_valid && !stall;
        if (!taken)               tgt = s.i_pc4;
        else if (s.i_brmode == 5) tgt = a;
        else                      tgt = s.i_pc4 + immx * 32'd4;
        c.stall = stall; c.redirect = taken; c.target = tgt;
        c.scnt = mscnt; c.rcnt = mrcnt;
        cq.push_back(c);
        if (stall && mscnt != 32'hFFFF_FFFF) mscnt++;
        if (taken && mrcnt != 32'hFFFF_FFFF) mrcnt++;
        if (stall || s.i_flush || !s.i_valid) begin
            mx_valid = 1'b0; mx_wreg = 1'b0; mx_m2reg = 1'b0; mx_rn = 5'd0;
        end else begin
            x.rn = s.i_wr; x.wreg = s.i_wreg; x.m2reg = s.i_m2reg;
            x.a = a; x.b = b; x.imm = immx; x.ctrl = s.i_ctrl;
            xq.push_back(x);
            mx_valid = 1'b1; mx_wreg = s.i_wreg; mx_m2reg = s.i_m2reg; mx_rn = s.i_wr;
        end
        if (s.w_wreg && s.w_rn != 5'd0) mregs[s.w_rn] = s.w_data;
    endtask

    task automatic drive(input stim_t s);
        bus.i_valid = s.i_valid;   bus.i_pc4 = s.i_pc4;
        bus.i_rs = s.i_rs;         bus.i_rt = s.i_rt;        bus.i_wr = s.i_wr;
        bus.i_imm = s.i_imm;       bus.i_sext = s.i_sext;
        bus.i_use_rs = s.i_use_rs; bus.i_use_rt = s.i_use_rt;
        bus.i_wreg = s.i_wreg;     bus.i_m2reg = s.i_m2reg;
        bus.i_brmode = s.i_brmode; bus.i_ctrl = s.i_ctrl;    bus.i_flush = s.i_flush;
        bus.ealu = s.ealu;
        bus.m_wreg = s.m_wreg;     bus.m_m2reg = s.m_m2reg;  bus.m_rn = s.m_rn;
        bus.malu = s.malu;         bus.mmo = s.mmo;
        bus.w_wreg = s.w_wreg;     bus.w_rn = s.w_rn;        bus.w_data = s.w_data;
    endtask

    task automatic apply(input stim_t s);
        @(negedge clk);
        drive(s);
        model(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Operand values biased toward a few repeats so beq/bne and sign tests hit both ways.
    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0010;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFF0;
            default: return $urandom;
        endcase
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.i_valid  = ($urandom_range(0, 9) != 0);
        s.i_pc4    = $urandom;
        s.i_rs     = 5'($urandom_range(0, 7));
        s.i_rt     = 5'($urandom_range(0, 7));
        s.i_wr     = 5'($urandom_range(0, 7));
        s.i_imm    = 16'($urandom);
        s.i_sext   = 1'($urandom_range(0, 1));
        s.i_use_rs = ($urandom_range(0, 3) != 0);
        s.i_use_rt = ($urandom_range(0, 3) != 0);
        s.i_wreg   = 1'($urandom_range(0, 1));
        s.i_m2reg  = ($urandom_range(0, 2) == 0);
        s.i_brmode = 3'($urandom_range(0, 7));
        s.i_ctrl   = 8'($urandom);
        s.i_flush  = ($urandom_range(0, 9) == 0);
        s.ealu     = rval();
        s.m_wreg   = 1'($urandom_range(0, 1));
        s.m_m2reg  = 1'($urandom_range(0, 1));
        s.m_rn     = 5'($urandom_range(0, 7));
        s.malu     = rval();
        s.mmo      = rval();
        s.w_wreg   = 1'($urandom_range(0, 1));
        s.w_rn     = 5'($urandom_range(0, 7));
        s.w_data   = rval();
        return s;
    endfunction

    // Combinational outputs, checked after they settle following the drive edge.
    initial begin : mon_comb
        comb_t c;
        forever begin
            @(negedge clk);
            #2;
            if (resetn && cq.size() > 0) begin
                c = cq.pop_front();
                chk("o_stall", 32'(bus.o_stall), 32'(c.stall));
                chk("o_redirect", 32'(bus.o_redirect), 32'(c.redirect));
                chk("o_target", bus.o_target, c.target);
`ifdef PIPEID_PERF_EN
                chk("o_stall_cnt", bus.o_stall_cnt, c.scnt);
                chk("o_redir_cnt", bus.o_redir_cnt, c.rcnt);
`endif
            end
        end
    end

    // ID/EX register: pop an expected entry whenever the DUT presents x_valid.
    initial begin : mon_x
        xexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (resetn) begin
                if (bus.x_valid) begin
                    if (xq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL x_unexpected: got x_valid=1, expected no entry (t=%0t)", $time);
                    end else begin
                        e = xq.pop_front();
                        chk("x_rn", 32'(bus.x_rn), 32'(e.rn));
                        chk("x_wreg", 32'(bus.x_wreg), 32'(e.wreg));
                        chk("x_m2reg", 32'(bus.x_m2reg), 32'(e.m2reg));
                        chk("x_a", bus.x_a, e.a);
                        chk("x_b", bus.x_b, e.b);
                        chk("x_imm", bus.x_imm, e.imm);
                        chk("x_ctrl", 32'(bus.x_ctrl), 32'(e.ctrl));
                    end
                end else begin
                    chk("bubble_wreg", 32'(bus.x_wreg), 32'd0);
                    chk("bubble_m2reg", 32'(bus.x_m2reg), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        stim_t s;
        resetn = 1'b0;
        drive(idle());
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
        chk("rst_x_a", bus.x_a, 32'd0);
        chk("rst_x_b", bus.x_b, 32'd0);
        chk("rst_o_stall", 32'(bus.o_stall), 32'd0);

        // r0 write is ignored, and every register reads zero after reset
        s = idle(); s.w_wreg = 1'b1; s.w_rn = 5'd0; s.w_data = 32'h55; apply(s);
        s = idle(); s.i_valid = 1'b1; s.i_use_rs = 1'b1; s.i_rs = 5'd0; apply(s);
        for (int i = 0; i < 32; i++) begin
            s = idle(); s.i_valid = 1'b1; s.i_rs = 5'(i); s.i_rt = 5'(31 - i); apply(s);
        end

        // same-cycle WB bypass
        s = idle(); s.i_valid = 1'b1; s.i_rs = 5'd3; s.i_use_rs = 1'b1;
        s.w_wreg = 1'b1; s.w_rn = 5'd3; s.w_data = 32'h1234; apply(s);

        // EX forward beats MEM forward
        s = idle(); s.i_valid = 1'b1; s.i_wr = 5'd4; s.i_wreg = 1'b1; apply(s);
        s = idle(); s.i_valid = 1'b1; s.i_rs = 5'd4; s.i_use_rs = 1'b1; s.ealu = 32'd7;
        s.m_wreg = 1'b1; s.m_rn = 5'd4; s.malu = 32'd9; apply(s);

        // load-use: one stall, then forward the load data from MEM
        s = idle(); s.i_valid = 1'b1; s.i_wr = 5'd5; s.i_wreg = 1'b1; s.i_m2reg = 1'b1; apply(s);
        s = idle(); s.i_valid = 1'b1; s.i_rt = 5'd5; s.i_use_rt = 1'b1; apply(s);
        s.m_wreg = 1'b1; s.m_m2reg = 1'b1; s.m_rn = 5'd5; s.mmo = 32'hAA; apply(s);

        // branch operands
        s = idle(); s.w_wreg = 1'b1; s.w_rn = 5'd1; s.w_data = 32'h10; apply(s);
        s.w_rn = 5'd2; apply(s);
        s.w_rn = 5'd6; s.w_data = 32'h8000_0000; apply(s);
        s.w_rn = 5'd7; s.w_data = 32'h400; apply(s);
        s = idle(); s.i_valid = 1'b1; s.i_rs = 5'd1; s.i_rt = 5'd2;
        s.i_use_rs = 1'b1; s.i_use_rt = 1'b1; s.i_pc4 = 32'h100;
        s.i_imm = 16'hFFFF; s.i_sext = 1'b1; s.i_brmode = 3'd1; apply(s);
        s.i_brmode = 3'd2; apply(s);
        s.i_rs = 5'd6; s.i_brmode = 3'd3; apply(s);
        s.i_rs = 5'd7; s.i_brmode = 3'd5; apply(s);

        // flush of a valid instruction
        s = idle(); s.i_valid = 1'b1; s.i_wreg = 1'b1; s.i_wr = 5'd9; s.i_flush = 1'b1; apply(s);

        for (int n = 0; n < 1500; n++) apply(rnd());

        // reset asserted in the middle of a load-use stall
        s = idle(); s.i_valid = 1'b1; s.i_wr = 5'd5; s.i_wreg = 1'b1; s.i_m2reg = 1'b1; apply(s);
        s = idle(); s.i_valid = 1'b1; s.i_rs = 5'd5; s.i_use_rs = 1'b1; apply(s);
        #3;
        resetn = 1'b0;
        drive(idle());
        #1;
        chk("rst_stall_o_stall", 32'(bus.o_stall), 32'd0);
        chk("rst_stall_x_valid", 32'(bus.x_valid), 32'd0);
        chk("rst_stall_x_a", bus.x_a, 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        for (int n = 0; n < 200; n++) apply(rnd());
        apply(idle());
        repeat (2) @(posedge clk);
        #2;
        chk("sb_x_drained", 32'(xq.size()), 32'd0);
        chk("sb_comb_drained", 32'(cq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_id_regfwd.md
Name: pipe_id_regfwd

Overview:
- Parametrised decode/operand stage for the pipelined CPU.
- Contains the register file, EX/MEM/WB forwarding, load-use interlock, in-ID branch resolution with extended compare modes, and the ID/EX pipeline register with flush.
- Sits between the IF/ID register and the EX stage. Instruction-field split and control decode stay in the separate control unit; control fields arrive here pre-decoded.

Parameters:
- XLEN, 32, datapath/register width.
- RA_W, 5, register address width; register file holds 2**RA_W entries, entry 0 reads as zero.
- CW, 8, width of opaque EX/MEM control bundle passed through.

Ports:
- clock in 1: single clock, rising edge.
- resetn in 1: asynchronous, active-low reset.
- i_valid in 1: ID holds a real instruction.
- i_pc4 in XLEN: PC+4 of the ID instruction.
- i_rs, i_rt in RA_W: source registers.
- i_wr in RA_W: destination, already selected rd/rt/31.
- i_imm in 16: immediate.
- i_sext in 1: sign-extend immediate.
- i_use_rs, i_use_rt in 1: source actually read.
- i_wreg, i_m2reg in 1: writes register / is load.
- i_brmode in 3: 000 none, 001 beq, 010 bne, 011 bltz, 100 bgez, 101 jr; others treated as none.
- i_ctrl in CW: pass-through control.
- i_flush in 1: squash the instruction entering ID/EX.
- ealu in XLEN: EX-stage ALU result.
- m_wreg, m_m2reg in 1; m_rn in RA_W; malu, mmo in XLEN: MEM-stage writeback info, ALU result, load data.
- w_wreg in 1; w_rn in RA_W; w_data in XLEN: writeback port.
- o_stall out 1: hold PC and IF/ID.
- o_redirect out 1; o_target out XLEN: taken branch/jr.
- x_valid, x_wreg, x_m2reg out 1; x_rn out RA_W; x_a, x_b, x_imm out XLEN; x_ctrl out CW: ID/EX register.

Behaviour:
- Reset (async, resetn=0): all x_* outputs 0; all register-file entries 0; perf counters 0.
- Register file write: at the rising edge when w_wreg=1 and w_rn!=0. Writes to r0 are ignored.
- Register file read: combinational. Same-cycle WB write to the source register is bypassed (w_data returned).
- Forward select per source s (rs/rt), first match wins:
  - s==0 → 0.
  - x_valid & x_wreg & ~x_m2reg & x_rn==s → ealu.
  - m_wreg & m_rn==s → mmo if m_m2reg, else malu.
  - Otherwise → register file (with WB bypass).
- Load-use hazard: o_stall = i_valid & x_valid & x_m2reg & x_wreg & x_rn!=0 & ((i_use_rs & x_rn==i_rs) | (i_use_rt & x_rn==i_rt)). Applies equally to branch operands. Costs exactly 1 bubble cycle.
- Immediate: imm_ext = {XLEN-16 copies of (i_sext & i_imm[15]), i_imm}.
- Branch (only when i_valid & ~o_stall; uses forwarded a/b):
  - beq taken: a==b. bne taken: a!=b. bltz taken: a[XLEN-1]=1. bgez taken: a[XLEN-1]=0. jr: always taken.
  - o_target = jr ? a : i_pc4 + (imm_ext<<2), modulo 2**XLEN.
  - o_redirect = taken. Combinational, same cycle as ID. Delay-slot semantics: the fetched instruction is not squashed by this block.
- When not taken: o_redirect=0 and o_target = i_pc4.
- ID/EX update, every rising edge:
  - bubble = o_stall | i_flush | ~i_valid → x_valid=0, x_wreg=0, x_m2reg=0; other x_* don't-care (implementation holds them at 0).
  - Otherwise x_a/x_b = forwarded values, x_imm = imm_ext, x_rn = i_wr, x_wreg = i_wreg, x_m2reg = i_m2reg, x_ctrl = i_ctrl, x_valid=1.
- i_flush takes priority with no extra effect; flush with stall still yields a single bubble.
- Reset asserted mid-stall: everything clears; o_stall drops because x_valid=0.

Optional Feature:
- Macro PIPEID_PERF_EN.
- Defined: adds outputs o_stall_cnt[31:0] and o_redir_cnt[31:0].
  - o_stall_cnt increments on each rising edge with o_stall=1.
  - o_redir_cnt increments on each rising edge with o_redirect=1.
  - Both saturate at 0xFFFFFFFF; both clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset → x_valid=0, x_a=0; all 2**RA_W registers read 0. Write r0=0x55 via WB → r0 still reads 0.
- WB writes r3=0x1234 while ID reads rs=3 in the same cycle → x_a=0x1234 at the next edge.
- x_rn=4 ALU op, ealu=7; MEM m_rn=4 malu=9; ID add rs=4 → x_a=7 (EX beats MEM).
- Load to r5 in EX, ID uses rt=5 → o_stall=1 for one cycle and a bubble (x_valid=0) is inserted. Next cycle MEM has m_m2reg=1, mmo=0xAA → x_b=0xAA, o_stall=0.
- beq with a=b=0x10, i_pc4=0x100, imm=0xFFFF, sext → o_redirect=1, o_target=0xFC. bne with the same operands → o_redirect=0. bltz with a=0x80000000 → taken. jr with a=0x400 → o_target=0x400.
- i_flush=1 with a valid instruction → x_valid=0, x_wreg=0. With PIPEID_PERF_EN: 3 stall cycles plus 2 redirects → o_stall_cnt=3, o_redir_cnt=2.
